pwm_meas: RTL

//  Capture-side companion to the PWM generator. Samples an incoming PWM waveform and measures its period and high time in clk cycles.

---
 rtl/pwm_meas.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_meas.sv
// Measures period and high time of an asynchronous PWM input in clk cycles.
// Latency: meas_valid two clk edges after the synchroniser first sees the rising edge.
// No backpressure: results are one-cycle strobes; optional glitch filter via PWM_MEAS_FILTER_EN.
module pwm_meas #(
    parameter int CNT_W    = 8,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] duty_out,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_level
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // A filter length of zero would never let the filtered level move.
    if (FILT_LEN < 1) begin : g_filt_len_check
        $error("pwm_meas: FILT_LEN must be at least 1");
    end

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic lvl;
    logic rise;
    logic fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] period_out_q, period_out_d;
    logic [CNT_W-1:0] duty_out_q, duty_out_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_q, timeout_d;
    logic             stuck_level_q, stuck_level_d;

    // Two-flop synchroniser, then s3 remembers the previous level for edge detection.
    always_comb begin
        s1_d = pwm_in;
        s2_d = s1_q;
        s3_d = lvl;
    end

`ifdef PWM_MEAS_FILTER_EN
    localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic            flt_q, flt_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;

    // Filtered level follows s2 only after FILT_LEN consecutive disagreeing samples.
    always_comb begin
        flt_d  = flt_q;
        fcnt_d = '0;
        if (s2_q != flt_q) begin
            if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
                flt_d = s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_q  <= 1'b0;
            fcnt_q <= '0;
        end else begin
            flt_q  <= flt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = flt_q;
`else
    assign lvl = s2_q;
`endif

    assign rise = lvl & ~s3_q;
    assign fall = ~lvl & s3_q;

    // Measurement FSM: count from each rise, latch high time on fall, publish on the next rise.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        duty_d        = duty_q;
        period_out_d  = period_out_q;
        duty_out_d    = duty_out_q;
        meas_valid_d  = 1'b0;
        timeout_d     = 1'b0;
        stuck_level_d = stuck_level_q;

        if (rise) begin
            cnt_d = CNT_ONE;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                // First partial period is discarded; only arm on a rise.
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    // A fall landing on the last count still means the period cannot fit.
                    state_d       = IDLE;
                    cnt_d         = '0;
                    timeout_d     = 1'b1;
                    stuck_level_d = s3_q;
                end else if (fall) begin
                    duty_d  = cnt_q;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    period_out_d = cnt_q;
                    duty_out_d   = duty_q;
                    meas_valid_d = 1'b1;
                    state_d      = HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    timeout_d     = 1'b1;
                    stuck_level_d = s3_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any partial measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            duty_q        <= '0;
            period_out_q  <= '0;
            duty_out_q    <= '0;
            meas_valid_q  <= 1'b0;
            timeout_q     <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            duty_q        <= duty_d;
            period_out_q  <= period_out_d;
            duty_out_q    <= duty_out_d;
            meas_valid_q  <= meas_valid_d;
            timeout_q     <= timeout_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign period_out  = period_out_q;
    assign duty_out    = duty_out_q;
    assign meas_valid  = meas_valid_q;
    assign timeout     = timeout_q;
    assign stuck_level = stuck_level_q;

endmodule
